// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage encoding for the union-find decoder array.
// The controller state and the global_stage broadcast share this encoding.
package decoder_stage_controller_pkg;

  localparam int unsigned STAGE_WIDTH = 3;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_PEELING             = 3'd4,
    STAGE_RESULT_VALID        = 3'd5
  } stage_e;

endpackage

// File: rtl/decoder_stage_controller_if.sv
// Bundle between the stage controller and its environment.
//   master: drives start, per-PE busy/odd; observes stage and round statistics
//   slave : the controller itself
interface decoder_stage_controller_if
  import decoder_stage_controller_pkg::*;
#(
  parameter int unsigned PE_COUNT    = 72,
  parameter int unsigned ITER_WIDTH  = 8,
  parameter int unsigned CYCLE_WIDTH = 16
);

  logic                   start;
  logic [PE_COUNT-1:0]    busy;
  logic [PE_COUNT-1:0]    odd;
  stage_e                 global_stage;
  logic                   measurement_ack;
  logic                   result_valid;
  logic                   overflow;
  logic [ITER_WIDTH-1:0]  iteration_count;
  logic [CYCLE_WIDTH-1:0] cycle_count;

  modport master (
    output start, busy, odd,
    input  global_stage, measurement_ack, result_valid, overflow,
           iteration_count, cycle_count
  );

  modport slave (
    input  start, busy, odd,
    output global_stage, measurement_ack, result_valid, overflow,
           iteration_count, cycle_count
  );

endinterface

// File: rtl/decoder_stage_controller_stage_quiet_detector.sv
// Settle + quiet detector shared by MERGE and PEELING.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart both counters (stage entry)
//   any_busy   : registered OR of per-PE busy
//   done       : this cycle completes QUIET_CYCLES idle cycles after settling
module stage_quiet_detector #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned QUIET_CYCLES  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic any_busy,
  output logic done
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);

  logic [SW-1:0] settle_q;
  logic [QW-1:0] quiet_q;
  logic          settled;

  assign settled = (settle_q == SW'(SETTLE_CYCLES));
  // Done in the cycle whose idle busy completes the quiet run
  assign done = settled && !any_busy && (quiet_q == QW'(QUIET_CYCLES - 1));

  // Busy is ignored while settling; any busy afterwards restarts the quiet run
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      settle_q <= '0;
      quiet_q  <= '0;
    end else if (!settled) begin
      settle_q <= settle_q + SW'(1);
    end else if (any_busy) begin
      quiet_q <= '0;
    end else if (quiet_q != QW'(QUIET_CYCLES)) begin
      quiet_q <= quiet_q + QW'(1);
    end
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the union-find decoder array.
//   clk, reset : clock, synchronous active-high reset
//   bus.start  : begin a round (IDLE only)
//   bus.busy/odd : per-PE flags, OR-reduced into registers
//   bus.global_stage : stage broadcast (== controller state)
//   bus.measurement_ack, result_valid, overflow, iteration_count, cycle_count
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int unsigned PE_COUNT       = 72,
  parameter int unsigned MAX_ITERATIONS = 31,
  parameter int unsigned LOAD_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned QUIET_CYCLES   = 2,
  parameter int unsigned ITER_WIDTH     = 8,
  parameter int unsigned CYCLE_WIDTH    = 16
) (
  input logic                        clk,
  input logic                        reset,
  decoder_stage_controller_if.slave  bus
);

  localparam int unsigned LOAD_W = $clog2(LOAD_CYCLES + 1);

  stage_e                 state_q, state_d;
  logic                   any_busy_q, any_odd_q;
  logic [LOAD_W-1:0]      load_cnt_q;
  logic [ITER_WIDTH-1:0]  iter_q;
  logic [CYCLE_WIDTH-1:0] cycle_q;
  logic                   ack_q, rv_q, ovf_q;
  logic                   quiet_done_c, ovf_set_c, stage_entry_c, start_ok_c;

  assign start_ok_c    = (state_q == STAGE_IDLE) && bus.start;
  assign stage_entry_c = (state_d != state_q);

  stage_quiet_detector #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .QUIET_CYCLES  (QUIET_CYCLES)
  ) u_quiet (
    .clk      (clk),
    .reset    (reset),
    .clear    (stage_entry_c),
    .any_busy (any_busy_q),
    .done     (quiet_done_c)
  );

  // Next-stage selection
  always_comb begin
    state_d   = state_q;
    ovf_set_c = 1'b0;
    unique case (state_q)
      STAGE_IDLE:
        if (bus.start) state_d = STAGE_MEASUREMENT_LOADING;
      STAGE_MEASUREMENT_LOADING:
        if (load_cnt_q == LOAD_W'(LOAD_CYCLES - 1)) state_d = STAGE_GROW;
      STAGE_GROW:
        state_d = STAGE_MERGE;
      STAGE_MERGE:
        if (quiet_done_c) begin
          if (!any_odd_q) begin
            state_d = STAGE_PEELING;
          end else if (iter_q >= ITER_WIDTH'(MAX_ITERATIONS)) begin
            ovf_set_c = 1'b1;
            state_d   = STAGE_PEELING;
          end else begin
            state_d = STAGE_GROW;
          end
        end
      STAGE_PEELING:
        if (quiet_done_c) state_d = STAGE_RESULT_VALID;
      STAGE_RESULT_VALID:
        state_d = STAGE_IDLE;
      default:
        state_d = STAGE_IDLE;
    endcase
  end

  // State, reductions and round statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STAGE_IDLE;
      any_busy_q <= 1'b0;
      any_odd_q  <= 1'b0;
      load_cnt_q <= '0;
      iter_q     <= '0;
      cycle_q    <= '0;
      ack_q      <= 1'b0;
      rv_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      any_busy_q <= |bus.busy[PE_COUNT-1:0];
      any_odd_q  <= |bus.odd[PE_COUNT-1:0];
      load_cnt_q <= (state_q == STAGE_MEASUREMENT_LOADING) ? load_cnt_q + LOAD_W'(1) : '0;
      ack_q      <= start_ok_c;
      rv_q       <= (state_d == STAGE_RESULT_VALID);
      if (start_ok_c) begin
        // First LOAD cycle is the first counted cycle
        iter_q  <= '0;
        cycle_q <= CYCLE_WIDTH'(1);
        ovf_q   <= 1'b0;
      end else begin
        if (state_d == STAGE_GROW) iter_q <= iter_q + ITER_WIDTH'(1);
        if (state_q != STAGE_IDLE && state_d != STAGE_IDLE && cycle_q != '1)
          cycle_q <= cycle_q + CYCLE_WIDTH'(1);
        if (ovf_set_c) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.global_stage    = state_q;
  assign bus.measurement_ack = ack_q;
  assign bus.result_valid    = rv_q;
  assign bus.overflow        = ovf_q;
  assign bus.iteration_count = iter_q;
  assign bus.cycle_count     = cycle_q;

endmodule
